// File: rtl/sync_updown_mod_counter_pkg.sv
// Shared definitions for the up/down modulo counter.
//   DIR_UP / DIR_DOWN : encodings of the up_dn input
//   params_legal()    : WIDTH/MODULUS legality check, evaluated at elaboration
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 16;

   // WIDTH must be 2..16 and MODULUS 2..2**WIDTH.
   function automatic bit params_legal(input int width, input int modulus);
      if (width < MIN_WIDTH || width > MAX_WIDTH) return 1'b0;
      if (modulus < 2 || modulus > (1 << width))  return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/sync_updown_mod_counter_if.sv
// Control/status bundle of the counter.
//   en, up_dn, load, d : driven by the controller (master)
//   q, tc, wrap        : driven by the counter (slave)
interface sync_updown_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;

   modport master (
      output en, up_dn, load, d,
      input  q, tc, wrap
   );

   modport slave (
      input  en, up_dn, load, d,
      output q, tc, wrap
   );
endinterface

// File: rtl/sync_updown_mod_counter_jk_ff.sv
// JK flip-flop with synchronous active-high reset.
//   j, k  : 00 hold, 01 clear, 10 set, 11 toggle
//   clk   : rising-edge clock
//   reset : synchronous, active-high, clears q
//   q     : registered output
module jk_ff (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);
   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      unique case ({j, k})
         2'b00: q_d = q_q;
         2'b01: q_d = 1'b0;
         2'b10: q_d = 1'b1;
         2'b11: q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) q_q <= 1'b0;
      else       q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/sync_updown_mod_counter.sv
// Synchronous up/down modulo-MODULUS counter built from JK flip-flops.
//   clk, reset : clock and synchronous active-high reset
//   bus.en     : advance one step per cycle
//   bus.up_dn  : 1 = up, 0 = down
//   bus.load   : parallel load of bus.d (clamped to MODULUS-1)
//   bus.q      : registered count
//   bus.tc     : terminal count for the current direction (combinational)
//   bus.wrap   : one-cycle registered pulse after a modulus wrap
// Priority per edge: reset > load > en > hold.
module sync_updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   sync_updown_mod_counter_if.slave        bus
);

   if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
      $error("sync_updown_mod_counter: illegal WIDTH/MODULUS combination");
   end

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] jk_j;
   logic [WIDTH-1:0] jk_k;
   logic             force_d;    // load or wrap: drive J/K as set/clear
   logic             at_tc;
   logic             wrap_d;
   logic             wrap_q;

   assign at_tc = (bus.up_dn == DIR_UP) ? (cnt_q == MAX_CNT) : (cnt_q == '0);

   always_comb begin
      cnt_d   = cnt_q;
      force_d = 1'b0;
      wrap_d  = 1'b0;
      if (bus.load) begin
         // Out-of-range load values clamp so no illegal state is reachable.
         cnt_d   = (32'(bus.d) >= 32'(MODULUS)) ? MAX_CNT : bus.d;
         force_d = 1'b1;
      end else if (bus.en) begin
         if (at_tc) begin
            cnt_d   = (bus.up_dn == DIR_UP) ? '0 : MAX_CNT;
            force_d = 1'b1;
            wrap_d  = 1'b1;
         end else if (bus.up_dn == DIR_UP) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Plain counting toggles the bits that change; load/wrap set or clear
   // every bit explicitly.
   always_comb begin
      jk_j = cnt_q ^ cnt_d;
      jk_k = cnt_q ^ cnt_d;
      if (force_d) begin
         jk_j = cnt_d;
         jk_k = ~cnt_d;
      end
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      jk_ff u_jk (
         .clk   (clk),
         .reset (reset),
         .j     (jk_j[b]),
         .k     (jk_k[b]),
         .q     (cnt_q[b])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) wrap_q <= 1'b0;
      else       wrap_q <= wrap_d;
   end

   assign bus.q    = cnt_q;
   assign bus.tc   = at_tc;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
module tb_sync_updown_mod_counter;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   sync_updown_mod_counter_if #(.WIDTH(4)) bus10 ();
   sync_updown_mod_counter_if #(.WIDTH(4)) bus16 ();

   sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus10)
   );

   sync_updown_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus10.en = 1'b0; bus10.up_dn = 1'b1; bus10.load = 1'b0; bus10.d = 4'd0;
      bus16.en = 1'b0; bus16.up_dn = 1'b1; bus16.load = 1'b0; bus16.d = 4'd0;
      #12;
      checks++;
      if (bus10.q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", bus10.q); end
      checks++;
      if (bus10.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", bus10.wrap); end
      checks++;
      if (bus10.tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up: got %b want 0", bus10.tc); end
      bus10.up_dn = 1'b0;
      #1;
      checks++;
      if (bus10.tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down: got %b want 1", bus10.tc); end
      bus10.up_dn = 1'b1;
      reset = 1'b0;
      bus10.en = 1'b1;
   endtask

   task automatic test_count_up;
      int exp_q;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp_q = i % 10;
         checks++;
         if (bus10.q !== 4'(exp_q)) begin errors++; $display("FAIL up_q[%0d]: got %0d want %0d", i, bus10.q, exp_q); end
         checks++;
         if (bus10.tc !== (exp_q == 9)) begin errors++; $display("FAIL up_tc[%0d]: got %b want %b", i, bus10.tc, exp_q == 9); end
         checks++;
         if (bus10.wrap !== (i == 10)) begin errors++; $display("FAIL up_wrap[%0d]: got %b want %b", i, bus10.wrap, i == 10); end
      end
   endtask

   task automatic test_count_down;
      int exp_q;
      bus10.up_dn = 1'b0;
      #1;
      checks++;
      if (bus10.tc !== 1'b1) begin errors++; $display("FAIL down_tc_start: got %b want 1", bus10.tc); end
      for (int i = 1; i <= 11; i++) begin
         tick();
         exp_q = (10 - (i % 10)) % 10;
         checks++;
         if (bus10.q !== 4'(exp_q)) begin errors++; $display("FAIL down_q[%0d]: got %0d want %0d", i, bus10.q, exp_q); end
         checks++;
         if (bus10.tc !== (exp_q == 0)) begin errors++; $display("FAIL down_tc[%0d]: got %b want %b", i, bus10.tc, exp_q == 0); end
         checks++;
         if (bus10.wrap !== (i == 1 || i == 11)) begin errors++; $display("FAIL down_wrap[%0d]: got %b want %b", i, bus10.wrap, i == 1 || i == 11); end
      end
   endtask

   task automatic test_load;
      // q is 9, counting down
      bus10.en = 1'b1; bus10.load = 1'b1; bus10.d = 4'd7;
      tick();
      checks++;
      if (bus10.q !== 4'd7) begin errors++; $display("FAIL load7_q: got %0d want 7", bus10.q); end
      checks++;
      if (bus10.wrap !== 1'b0) begin errors++; $display("FAIL load7_wrap: got %b want 0", bus10.wrap); end
      bus10.d = 4'd13;
      tick();
      checks++;
      if (bus10.q !== 4'd9) begin errors++; $display("FAIL load_clamp_q: got %0d want 9", bus10.q); end
      checks++;
      if (bus10.wrap !== 1'b0) begin errors++; $display("FAIL load_clamp_wrap: got %b want 0", bus10.wrap); end
      // q=9 counting up is terminal count: the load must win and not wrap.
      bus10.up_dn = 1'b1; bus10.d = 4'd2;
      #1;
      checks++;
      if (bus10.tc !== 1'b1) begin errors++; $display("FAIL load_tc_pre: got %b want 1", bus10.tc); end
      tick();
      checks++;
      if (bus10.q !== 4'd2) begin errors++; $display("FAIL load_at_tc_q: got %0d want 2", bus10.q); end
      checks++;
      if (bus10.wrap !== 1'b0) begin errors++; $display("FAIL load_at_tc_wrap: got %b want 0", bus10.wrap); end
      bus10.load = 1'b0;
   endtask

   task automatic test_en_toggle;
      logic       en_pat [7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       dir_pat [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] exp_pat [7] = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd6, 4'd5};
      bus10.load = 1'b1; bus10.d = 4'd4; bus10.en = 1'b0;
      tick();
      bus10.load = 1'b0;
      checks++;
      if (bus10.q !== 4'd4) begin errors++; $display("FAIL toggle_setup_q: got %0d want 4", bus10.q); end
      for (int i = 0; i < 7; i++) begin
         bus10.en = en_pat[i];
         bus10.up_dn = dir_pat[i];
         tick();
         checks++;
         if (bus10.q !== exp_pat[i]) begin errors++; $display("FAIL toggle_q[%0d]: got %0d want %0d", i, bus10.q, exp_pat[i]); end
         checks++;
         if (bus10.wrap !== 1'b0) begin errors++; $display("FAIL toggle_wrap[%0d]: got %b want 0", i, bus10.wrap); end
      end
   endtask

   task automatic test_reset_mid;
      // q is 5; step up to 6
      bus10.en = 1'b1; bus10.up_dn = 1'b1;
      tick();
      checks++;
      if (bus10.q !== 4'd6) begin errors++; $display("FAIL rmid_setup_q: got %0d want 6", bus10.q); end
      reset = 1'b1; bus10.load = 1'b1; bus10.d = 4'd3;
      tick();
      checks++;
      if (bus10.q !== 4'd0) begin errors++; $display("FAIL rmid_q: got %0d want 0", bus10.q); end
      checks++;
      if (bus10.wrap !== 1'b0) begin errors++; $display("FAIL rmid_wrap: got %b want 0", bus10.wrap); end
      reset = 1'b0; bus10.load = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (bus10.q !== 4'(i)) begin errors++; $display("FAIL rmid_resume[%0d]: got %0d want %0d", i, bus10.q, i); end
      end
      bus10.en = 1'b0;
   endtask

   task automatic test_mod16;
      int exp_q;
      // dut16 has held 0 since reset
      checks++;
      if (bus16.q !== 4'd0) begin errors++; $display("FAIL m16_start_q: got %0d want 0", bus16.q); end
      bus16.en = 1'b1; bus16.up_dn = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         exp_q = i % 16;
         checks++;
         if (bus16.q !== 4'(exp_q)) begin errors++; $display("FAIL m16_up_q[%0d]: got %0d want %0d", i, bus16.q, exp_q); end
         checks++;
         if (bus16.wrap !== (i == 16)) begin errors++; $display("FAIL m16_up_wrap[%0d]: got %b want %b", i, bus16.wrap, i == 16); end
         checks++;
         if (bus16.tc !== (exp_q == 15)) begin errors++; $display("FAIL m16_up_tc[%0d]: got %b want %b", i, bus16.tc, exp_q == 15); end
      end
      bus16.up_dn = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         exp_q = (16 - i) % 16;
         checks++;
         if (bus16.q !== 4'(exp_q)) begin errors++; $display("FAIL m16_dn_q[%0d]: got %0d want %0d", i, bus16.q, exp_q); end
         checks++;
         if (bus16.wrap !== (i == 1)) begin errors++; $display("FAIL m16_dn_wrap[%0d]: got %b want %b", i, bus16.wrap, i == 1); end
      end
      bus16.en = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_en_toggle();
      test_reset_mid();
      test_mod16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
